// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    // Operation encodings for the sub input
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Bits per first-level lookahead group
    localparam int CLA_GRP = 4;

endpackage

// File: rtl/cla_slice.sv
// Combinational W-bit two-level carry-lookahead adder.
// Level 1 forms generate/propagate per 4-bit group; level 2 derives every
// group carry directly from cin and the group terms in sum-of-products form,
// and bit carries inside a group are expanded the same way, so nothing ripples.
module cla_slice
    import cla_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    localparam int NG = W / CLA_GRP;

    logic [W-1:0]  w_p;
    logic [W-1:0]  w_g;
    logic [W-1:0]  w_c;
    logic [NG-1:0] w_gg;
    logic [NG-1:0] w_gp;
    logic [NG:0]   w_cg;
    logic          w_term;

    // Two-level lookahead: group G/P, group carries, then bit carries
    always_comb begin
        w_p    = a ^ b;
        w_g    = a & b;
        w_gg   = '0;
        w_gp   = '0;
        w_cg   = '0;
        w_c    = '0;
        w_term = 1'b0;

        for (int j = 0; j < NG; j++) begin
            w_gp[j] = &w_p[j*CLA_GRP +: CLA_GRP];
            for (int i = 0; i < CLA_GRP; i++) begin
                w_term = w_g[j*CLA_GRP + i];
                for (int m = i + 1; m < CLA_GRP; m++)
                    w_term = w_term & w_p[j*CLA_GRP + m];
                w_gg[j] = w_gg[j] | w_term;
            end
        end

        for (int j = 0; j <= NG; j++) begin
            w_term = cin;
            for (int i = 0; i < j; i++)
                w_term = w_term & w_gp[i];
            w_cg[j] = w_term;
            for (int i = 0; i < j; i++) begin
                w_term = w_gg[i];
                for (int m = i + 1; m < j; m++)
                    w_term = w_term & w_gp[m];
                w_cg[j] = w_cg[j] | w_term;
            end
        end

        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < CLA_GRP; i++) begin
                w_term = w_cg[j];
                for (int m = 0; m < i; m++)
                    w_term = w_term & w_p[j*CLA_GRP + m];
                w_c[j*CLA_GRP + i] = w_term;
                for (int m = 0; m < i; m++) begin
                    w_term = w_g[j*CLA_GRP + m];
                    for (int n = m + 1; n < i; n++)
                        w_term = w_term & w_p[j*CLA_GRP + n];
                    w_c[j*CLA_GRP + i] = w_c[j*CLA_GRP + i] | w_term;
                end
            end
        end
    end

    assign s     = w_p ^ w_c;
    assign cout  = w_cg[NG];
    assign c_msb = w_c[W-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Stage k adds slice k and registers the merged word: sums of slices 0..k in
// the low bits, still-unused operand A bits above. Operand B and the slice
// carry travel alongside. The last stage register is the output register,
// so a beat sampled on an accepting edge appears after STAGES enabled edges.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH / CLA_GRP)) begin : g_bad_stages
        $error("cla_pipe_addsub: STAGES out of range 1..WIDTH/4");
    end
    if ((WIDTH % (CLA_GRP * ((STAGES < 1) ? 1 : STAGES))) != 0) begin : g_bad_width
        $error("cla_pipe_addsub: WIDTH must be a multiple of 4*STAGES");
    end

    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    logic [WIDTH-1:0] w_x_nxt [STAGES];
    logic [WIDTH-1:0] w_b_nxt [STAGES];
    logic             w_c_nxt [STAGES];
    logic             w_cm    [STAGES];

    logic [WIDTH-1:0] r_x [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic             r_c [STAGES];
    logic [STAGES-1:0] r_v;
    logic             r_ovf;
    logic             r_zero;

    // Whole pipeline moves together; a stalled output freezes every stage
    assign w_en      = out_ready || !out_valid;
    assign in_ready  = w_en;

    assign w_b_eff   = (sub == SUB) ? ~b : b;
    assign w_cin_eff = (sub == SUB) ? 1'b1 : c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int               LO   = k * SW;
        localparam logic [WIDTH-1:0] ONES = '1;
        localparam logic [WIDTH-1:0] MASK = (ONES >> (WIDTH - SW)) << LO;

        logic [WIDTH-1:0] w_x_in;
        logic [WIDTH-1:0] w_b_in;
        logic             w_ci;
        logic [SW-1:0]    w_s;
        logic             w_co;
        logic             w_cmsb;

        if (k == 0) begin : g_first
            assign w_x_in = a;
            assign w_b_in = w_b_eff;
            assign w_ci   = w_cin_eff;
        end else begin : g_next
            assign w_x_in = r_x[k-1];
            assign w_b_in = r_b[k-1];
            assign w_ci   = r_c[k-1];
        end

        cla_slice #(.W(SW)) u_slice (
            .a     (w_x_in[LO +: SW]),
            .b     (w_b_in[LO +: SW]),
            .cin   (w_ci),
            .s     (w_s),
            .cout  (w_co),
            .c_msb (w_cmsb)
        );

        assign w_x_nxt[k] = (w_x_in & ~MASK) | (WIDTH'(w_s) << LO);
        assign w_b_nxt[k] = w_b_in;
        assign w_c_nxt[k] = w_co;
        assign w_cm[k]    = w_cmsb;
    end

    // Advance all stage registers, valid chain and flags when enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_x[k] <= '0;
                r_b[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_v    <= '0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en) begin
            r_v[0] <= in_valid;
            for (int k = 1; k < STAGES; k++)
                r_v[k] <= r_v[k-1];
            for (int k = 0; k < STAGES; k++) begin
                r_x[k] <= w_x_nxt[k];
                r_b[k] <= w_b_nxt[k];
                r_c[k] <= w_c_nxt[k];
            end
            // Carry into the MSB differing from carry out is exactly the
            // same-sign-operands / flipped-result-sign overflow condition
            r_ovf  <= w_cm[STAGES-1] ^ w_c_nxt[STAGES-1];
            r_zero <= ~|w_x_nxt[STAGES-1];
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign sum       = r_x[STAGES-1];
    assign c_out     = r_c[STAGES-1];
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
